xgmii_rx_probe: RTL and testbench
=================================

# xgmii_rx_probe

Receive-side measurement stage for the 10G traffic tester. It sits directly downstream of the PHY RX XGMII, on the port that receives the tester's own generated IPv4/UDP probe frames. It parses each frame word by word and validates the probe signature. It then produces per-second frame and byte counts, per-frame one-way latency against the shared `global_counter`, and the last destination IPv4 address for the PCI register block.

## Interface
- `MAGIC_CODE`, default 32'hA5A5A5A5: probe signature carried in the UDP payload.
- `sys_clk`  in  1  156.25 MHz XGMII clock; all logic is on this clock.
- `sys_rst`  in  1  reset; asynchronous, active-high.
- `sec_oneshot`  in  1  one-cycle pulse once per second that closes the measurement window.
- `global_counter`  in  32  free-running cycle counter; the same one the transmitter stamps into frames.
- `xgmii_rxd`  in  64  XGMII RX data; lane n = bits [8n+7:8n]; lane 0 is first on the wire.
- `xgmii_rxc`  in  8  XGMII RX control, one bit per lane.
- `rx_pps`  out  32  valid probe frames counted in the last completed second.
- `rx_throughput`  out  32  bytes of valid probe frames in the last completed second.
- `rx_latency`  out  24  latency of the most recent valid frame, in cycles, saturating.
- `rx_latency_max`  out  24  maximum `rx_latency` seen since reset.
- `rx_ipv4_ip`  out  32  IPv4 destination address of the most recent valid frame.
- `rx_err_count`  out  32  cumulative count of aborted, runt or oversize frames; wraps.

## Operation
- Start word: `xgmii_rxc`=8'h01 and `xgmii_rxd`=64'hD5555555555555FB. In that cycle latch `arr_stamp`=`global_counter` and set the word index to 0.
- States:
  - IDLE: wait for a start word.
  - RECV: count words and capture fields.
  - DROP: wait for /T/ or an idle word.
- Field capture in RECV, by word index w (w=1 is the first word after start):
  - w2: ethertype = {lane4, lane5}, must be 16'h0800; version/IHL = lane6, must be 8'h45.
  - w3: IP protocol = lane7, must be 8'h11.
  - w4 lanes 6,7 and w5 lanes 0,1 form the destination IP, MSB first.
  - w6 lanes 2..5 form the magic, MSB first.
  - w6 lanes 6,7 and w7 lanes 0,1 form the 32-bit timestamp `ts`, MSB first.
- Terminate: the lowest lane k with rxc[k]=1 and rxd byte = 8'hFD.
  - Frame length L = 8*(w-1) + k bytes. This counts from the destination MAC through the FCS, excluding the preamble word.
  - The frame is valid if w ≥ 8 at terminate and ethertype, IHL, protocol and magic all match.
  - Valid frame: pps_acc += 1, byte_acc += L, update latency and `rx_ipv4_ip`.
  - Terminate with w < 8: increment `rx_err_count` (runt). Signature mismatch: silently ignored.
- Abort rules:
  - An /E/ byte (8'hFE with its rxc bit set) in any lane while in RECV: increment `rx_err_count`, go to DROP.
  - Any control lane in RECV that is neither /T/ nor the lanes after it (which must be 8'h07): treated the same as /E/.
  - w reaches 2047 without a terminate: oversize; increment the error count, go to DROP.
- DROP returns to IDLE on a word containing /T/ or an all-idle word (rxc=8'hFF).
- A start word seen in RECV aborts the current frame (error count +1) and begins a new frame from that word.
- Latency: d = `arr_stamp` − `ts` modulo 2^32. `rx_latency` = d[31:24]==0 ? d[23:0] : 24'hFFFFFF. `rx_latency_max` = max(previous, new).
- Window closing:
  - On `sec_oneshot`: `rx_pps` ← pps_acc and `rx_throughput` ← byte_acc.
  - The accumulators then clear. If a valid frame completes in the same cycle, the accumulators load 1 and L instead, so that frame is counted in the new window.
- Accumulators saturate at 32'hFFFFFFFF.

## Timing
- Reset (asynchronous): state IDLE; all outputs and accumulators 0.
- All outputs are registered.
- Stats, latency, IP and error count update on the clock edge after the terminate (or abort) word is sampled, i.e. 1-cycle latency.
- `rx_pps` and `rx_throughput` update on the edge after `sec_oneshot` is sampled high.
- Back-to-back frames: a start word in the cycle immediately after the /T/ word is accepted with no dead cycle.
- `sys_rst` asserted mid-frame discards the frame with no error increment, and the block restarts in IDLE.

## Test plan
- One 64-byte probe frame, ts=32'h00001000, start word sampled at `global_counter`=32'h00001234 → `rx_latency`=24'h000234, `rx_ipv4_ip`=captured destination IP; after `sec_oneshot`, `rx_pps`=1 and `rx_throughput`=64.
- 10 back-to-back 64-byte frames, then `sec_oneshot` coinciding with an 11th frame's terminate → `rx_pps`=10, `rx_throughput`=640; next window starts with pps_acc=1.
- Frame with magic 32'h12345678 → no counter change, `rx_err_count` unchanged.
- /E/ injected at w=4 → `rx_err_count`=1; the following valid frame is counted normally.
- Terminate at w=5 (runt) → `rx_err_count` +1; ts=32'hFF000000 with arr_stamp=0 → d=32'h01000000, so `rx_latency`=24'hFFFFFF and `rx_latency_max`=24'hFFFFFF.
- `sys_rst` pulsed at w=6 → all outputs 0; the next frame is measured correctly.

Source files
------------

// File: rtl/xgmii_rx_probe.sv
// Receive-side probe measurement: parses IPv4/UDP probe frames off the XGMII RX
// stream and produces per-second rate, byte, latency and error statistics.
module xgmii_rx_probe #(
  parameter logic [31:0] MAGIC_CODE = 32'hA5A5A5A5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        sec_oneshot,
  input  logic [31:0] global_counter,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [23:0] rx_latency_max,
  output logic [31:0] rx_ipv4_ip,
  output logic [31:0] rx_err_count
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_RECV     = 2'd1;
  localparam logic [1:0]  ST_DROP     = 2'd2;
  localparam logic [63:0] START_WORD  = 64'hD5555555555555FB;
  localparam logic [10:0] W_MAX       = 11'd2047;
  localparam logic [10:0] W_MIN_VALID = 11'd8;

  logic [1:0]  state_q, state_d;
  logic [10:0] w_q, w_d;
  logic [31:0] arr_stamp_q, arr_stamp_d;
  logic [31:0] ts_q, ts_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic        sig_ok_q, sig_ok_d;
  logic [31:0] pps_acc_q, pps_acc_d;
  logic [31:0] byte_acc_q, byte_acc_d;
  logic [31:0] rx_pps_q, rx_pps_d;
  logic [31:0] rx_thr_q, rx_thr_d;
  logic [23:0] lat_q, lat_d;
  logic [23:0] lat_max_q, lat_max_d;
  logic [31:0] ip_q, ip_d;
  logic [31:0] err_q, err_d;

  logic [7:0]  lane [8];
  logic        is_start, all_idle, term_any, term_found, ctrl_bad;
  logic [2:0]  term_lane;
  logic [10:0] cur_w;
  logic        in_recv, frame_end, frame_valid, frame_err;
  logic [31:0] frame_len, lat_diff;
  logic [23:0] lat_new;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFFFFFF : s[31:0];
  endfunction

  // Lane decode: /T/ is the lowest control lane and must read FD; every control
  // lane after it must be idle (07). Anything else in the word is an abort.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    term_found = 1'b0;
    term_any   = 1'b0;
    term_lane  = '0;
    ctrl_bad   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lane[k] = xgmii_rxd[8*k +: 8];
      if (xgmii_rxc[k]) begin
        if (lane[k] == 8'hFD) term_any = 1'b1;
        if (!term_found) begin
          if (lane[k] == 8'hFD) begin
            term_found = 1'b1;
            term_lane  = 3'(k);
          end else begin
            ctrl_bad = 1'b1;
          end
        end else if (lane[k] != 8'h07) begin
          ctrl_bad = 1'b1;
        end
      end
    end
  end

  assign is_start    = (xgmii_rxc == 8'h01) && (xgmii_rxd == START_WORD);
  assign all_idle    = (xgmii_rxc == 8'hFF);
  assign cur_w       = w_q + 11'd1;
  assign in_recv     = (state_q == ST_RECV);
  assign frame_end   = in_recv && !is_start && !ctrl_bad && term_found;
  assign frame_valid = frame_end && (cur_w >= W_MIN_VALID) && sig_ok_q;
  assign frame_err   = in_recv && (is_start || ctrl_bad ||
                                   (term_found && (cur_w < W_MIN_VALID)) ||
                                   (!term_found && (cur_w == W_MAX)));
  // w_q is the index of the previous word, i.e. (w - 1) for the /T/ word.
  assign frame_len   = 32'({w_q, 3'b000}) + 32'(term_lane);
  assign lat_diff    = arr_stamp_q - ts_q;
  assign lat_new     = (lat_diff[31:24] == 8'h00) ? lat_diff[23:0] : 24'hFFFFFF;

  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    arr_stamp_d = arr_stamp_q;
    ts_d        = ts_q;
    dst_ip_d    = dst_ip_q;
    sig_ok_d    = sig_ok_q;
    if (is_start && state_q != ST_DROP) begin
      state_d     = ST_RECV;
      w_d         = '0;
      arr_stamp_d = global_counter;
      sig_ok_d    = 1'b1;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (ctrl_bad)                state_d = ST_DROP;
          else if (term_found)         state_d = ST_IDLE;
          else if (cur_w == W_MAX)     state_d = ST_DROP;
          else begin
            w_d = cur_w;
            case (cur_w)
              11'd2: sig_ok_d = sig_ok_q && ({lane[4], lane[5]} == 16'h0800) &&
                                (lane[6] == 8'h45);
              11'd3: sig_ok_d = sig_ok_q && (lane[7] == 8'h11);
              11'd4: dst_ip_d[31:16] = {lane[6], lane[7]};
              11'd5: dst_ip_d[15:0]  = {lane[0], lane[1]};
              11'd6: begin
                sig_ok_d    = sig_ok_q &&
                              ({lane[2], lane[3], lane[4], lane[5]} == MAGIC_CODE);
                ts_d[31:16] = {lane[6], lane[7]};
              end
              11'd7: ts_d[15:0] = {lane[0], lane[1]};
              default: ;
            endcase
          end
        end
        ST_DROP: if (term_any || all_idle) state_d = ST_IDLE;
        ST_IDLE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A frame finishing in the closing cycle belongs to the new window.
  always_comb begin
    pps_acc_d  = pps_acc_q;
    byte_acc_d = byte_acc_q;
    rx_pps_d   = rx_pps_q;
    rx_thr_d   = rx_thr_q;
    lat_d      = lat_q;
    lat_max_d  = lat_max_q;
    ip_d       = ip_q;
    err_d      = err_q;
    if (sec_oneshot) begin
      rx_pps_d   = pps_acc_q;
      rx_thr_d   = byte_acc_q;
      pps_acc_d  = frame_valid ? 32'd1 : 32'd0;
      byte_acc_d = frame_valid ? frame_len : 32'd0;
    end else if (frame_valid) begin
      pps_acc_d  = sat_add(pps_acc_q, 32'd1);
      byte_acc_d = sat_add(byte_acc_q, frame_len);
    end
    if (frame_valid) begin
      lat_d     = lat_new;
      lat_max_d = (lat_new > lat_max_q) ? lat_new : lat_max_q;
      ip_d      = dst_ip_q;
    end
    if (frame_err) err_d = err_q + 32'd1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      arr_stamp_q <= '0;
      ts_q        <= '0;
      dst_ip_q    <= '0;
      sig_ok_q    <= 1'b0;
      pps_acc_q   <= '0;
      byte_acc_q  <= '0;
      rx_pps_q    <= '0;
      rx_thr_q    <= '0;
      lat_q       <= '0;
      lat_max_q   <= '0;
      ip_q        <= '0;
      err_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      w_q         <= w_d;
      arr_stamp_q <= arr_stamp_d;
      ts_q        <= ts_d;
      dst_ip_q    <= dst_ip_d;
      sig_ok_q    <= sig_ok_d;
      pps_acc_q   <= pps_acc_d;
      byte_acc_q  <= byte_acc_d;
      rx_pps_q    <= rx_pps_d;
      rx_thr_q    <= rx_thr_d;
      lat_q       <= lat_d;
      lat_max_q   <= lat_max_d;
      ip_q        <= ip_d;
      err_q       <= err_d;
    end
  end

  assign rx_pps         = rx_pps_q;
  assign rx_throughput  = rx_thr_q;
  assign rx_latency     = lat_q;
  assign rx_latency_max = lat_max_q;
  assign rx_ipv4_ip     = ip_q;
  assign rx_err_count   = err_q;

endmodule

// File: tb/tb_xgmii_rx_probe.sv
// Randomized frame-level bench for xgmii_rx_probe: frames are built as byte
// arrays, striped onto XGMII lanes, and outcomes predicted per frame.
module tb_xgmii_rx_probe;

  localparam logic [31:0] MAGIC   = 32'hA5A5A5A5;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        sec_oneshot;
  logic [31:0] global_counter;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip, rx_err_count;
  logic [23:0] rx_latency, rx_latency_max;

  xgmii_rx_probe #(.MAGIC_CODE(MAGIC)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .sec_oneshot    (sec_oneshot),
    .global_counter (global_counter),
    .xgmii_rxd      (xgmii_rxd),
    .xgmii_rxc      (xgmii_rxc),
    .rx_pps         (rx_pps),
    .rx_throughput  (rx_throughput),
    .rx_latency     (rx_latency),
    .rx_latency_max (rx_latency_max),
    .rx_ipv4_ip     (rx_ipv4_ip),
    .rx_err_count   (rx_err_count)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pps, m_thr, m_ip, m_err, m_pacc, m_bacc;
  logic [23:0] m_lat, m_lat_max;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pps"}, rx_pps, m_pps);
    check({tag, ".thr"}, rx_throughput, m_thr);
    check({tag, ".lat"}, {8'h00, rx_latency}, {8'h00, m_lat});
    check({tag, ".latmax"}, {8'h00, rx_latency_max}, {8'h00, m_lat_max});
    check({tag, ".ip"}, rx_ipv4_ip, m_ip);
    check({tag, ".err"}, rx_err_count, m_err);
  endtask

  function automatic logic [31:0] sat32(input longint v);
    longint lim;
    lim = 64'h0000_0000_FFFF_FFFF;
    return (v > lim) ? 32'hFFFFFFFF : v[31:0];
  endfunction

  task automatic model_reset();
    m_pps = '0; m_thr = '0; m_ip = '0; m_err = '0;
    m_pacc = '0; m_bacc = '0; m_lat = '0; m_lat_max = '0;
  endtask

  task automatic model_close(input bit valid, input int len);
    m_pps  = m_pacc;
    m_thr  = m_bacc;
    m_pacc = valid ? 32'd1 : 32'd0;
    m_bacc = valid ? 32'(len) : 32'd0;
  endtask

  // Frame-level outcome: restart/abort/runt/oversize are errors, else the
  // signature decides; window close and latency follow from the outcome.
  task automatic model_frame(input int len, input int bad, input int abort_w, input int trunc_w,
                             input bit osh, input logic [31:0] stamp, input logic [31:0] ts,
                             input logic [31:0] ip);
    bit valid;
    logic [31:0] d;
    valid = 1'b0;
    if (trunc_w != 0 || abort_w != 0 || len < 56 || len > 16375) m_err = m_err + 1;
    else valid = (bad == 0);
    if (osh) model_close(valid, len);
    else if (valid) begin
      m_pacc = sat32(longint'(m_pacc) + 1);
      m_bacc = sat32(longint'(m_bacc) + longint'(len));
    end
    if (valid) begin
      d = stamp - ts;
      m_lat = (d < 32'h0100_0000) ? d[23:0] : 24'hFFFFFF;
      if (m_lat > m_lat_max) m_lat_max = m_lat;
      m_ip = ip;
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic osh);
    @(negedge sys_clk);
    xgmii_rxd      = d;
    xgmii_rxc      = c;
    sec_oneshot    = osh;
    global_counter = global_counter + 1;
  endtask

  task automatic idle_gap(input int n, input bit osh);
    if (osh) begin
      drive(IDLE_W, 8'hFF, 1'b1);
      model_close(1'b0, 0);
    end
    for (int i = 0; i < n; i++) drive(IDLE_W, 8'hFF, 1'b0);
  endtask

  // bad: 0 none, 1 ethertype, 2 IHL, 3 protocol, 4 magic.
  task automatic send_frame(input int len, input int bad, input int abort_w, input int trunc_w,
                            input bit osh_term, input bit ts_abs, input logic [31:0] ts_arg,
                            input logic [31:0] ip, output logic [31:0] stamp,
                            output logic [31:0] ts);
    logic [7:0]  hdr [50];
    logic [7:0]  fb [];
    logic [31:0] magic;
    logic [63:0] d;
    logic [7:0]  c;
    int          n_words, idx;
    drive(START_W, 8'h01, 1'b0);
    stamp = global_counter;
    ts    = ts_abs ? ts_arg : stamp - ts_arg;
    magic = (bad == 4) ? 32'h12345678 : MAGIC;
    foreach (hdr[i]) hdr[i] = 8'($urandom);
    hdr[12] = (bad == 1) ? 8'h86 : 8'h08;
    hdr[13] = (bad == 1) ? 8'hDD : 8'h00;
    hdr[14] = (bad == 2) ? 8'h46 : 8'h45;
    hdr[23] = (bad == 3) ? 8'h06 : 8'h11;
    for (int i = 0; i < 4; i++) begin
      hdr[30 + i] = ip[31 - 8*i -: 8];
      hdr[42 + i] = magic[31 - 8*i -: 8];
      hdr[46 + i] = ts[31 - 8*i -: 8];
    end
    fb = new[len];
    foreach (fb[i]) fb[i] = (i < 50) ? hdr[i] : 8'($urandom);
    n_words = len / 8 + 1;
    for (int w = 1; w <= n_words; w++) begin
      if (trunc_w != 0 && w >= trunc_w) break;
      for (int j = 0; j < 8; j++) begin
        idx = 8 * (w - 1) + j;
        if (idx < len)       begin d[8*j +: 8] = fb[idx]; c[j] = 1'b0; end
        else if (idx == len) begin d[8*j +: 8] = 8'hFD;   c[j] = 1'b1; end
        else                 begin d[8*j +: 8] = 8'h07;   c[j] = 1'b1; end
      end
      if (w == abort_w) begin d[7:0] = 8'hFE; c[0] = 1'b1; end
      drive(d, c, osh_term && (w == n_words));
    end
  endtask

  initial begin
    logic [31:0] stamp, ts, ip, tsarg;
    int kind, len, bad, ab, tr, gap;
    bit osh, tsabs;

    sys_rst = 1'b1; sec_oneshot = 1'b0; global_counter = '0;
    xgmii_rxd = IDLE_W; xgmii_rxc = 8'hFF;
    model_reset();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    idle_gap(2, 1'b0);
    check_all("reset");

    // Single 64-byte frame with known stamp and timestamp.
    global_counter = 32'h1233;
    send_frame(64, 0, 0, 0, 1'b0, 1'b1, 32'h1000, 32'hC0A80A05, stamp, ts);
    model_frame(64, 0, 0, 0, 1'b0, stamp, ts, 32'hC0A80A05);
    idle_gap(1, 1'b0);
    check_all("single");
    check("single.lat_abs", {8'h00, rx_latency}, 32'h0000_0234);
    check("single.ip_abs", rx_ipv4_ip, 32'hC0A80A05);
    idle_gap(1, 1'b1);
    check("single.pps_abs", rx_pps, 32'd1);
    check("single.thr_abs", rx_throughput, 32'd64);

    // Ten back-to-back frames, then a window close on the eleventh's terminate.
    for (int i = 0; i < 11; i++) begin
      ip = $urandom;
      tsarg = $urandom_range(0, 3000);
      send_frame(64, 0, 0, 0, (i == 10), 1'b0, tsarg, ip, stamp, ts);
      model_frame(64, 0, 0, 0, (i == 10), stamp, ts, ip);
    end
    idle_gap(1, 1'b0);
    check_all("b2b");
    check("b2b.pps_abs", rx_pps, 32'd10);
    check("b2b.thr_abs", rx_throughput, 32'd640);
    idle_gap(1, 1'b1);
    check("b2b.next_pps", rx_pps, 32'd1);
    check("b2b.next_thr", rx_throughput, 32'd64);

    // Wrong magic: silently ignored.
    send_frame(80, 4, 0, 0, 1'b0, 1'b0, 32'd50, 32'h0A000001, stamp, ts);
    model_frame(80, 4, 0, 0, 1'b0, stamp, ts, 32'h0A000001);
    idle_gap(1, 1'b0);
    check_all("magic");
    check("magic.err_abs", rx_err_count, 32'd0);

    // /E/ at w=4, then a normal frame.
    send_frame(96, 0, 4, 0, 1'b0, 1'b0, 32'd70, 32'h0A000002, stamp, ts);
    model_frame(96, 0, 4, 0, 1'b0, stamp, ts, 32'h0A000002);
    idle_gap(1, 1'b0);
    check("abort.err_abs", rx_err_count, 32'd1);
    send_frame(72, 0, 0, 0, 1'b0, 1'b0, 32'd90, 32'h0A000003, stamp, ts);
    model_frame(72, 0, 0, 0, 1'b0, stamp, ts, 32'h0A000003);
    idle_gap(1, 1'b0);
    check_all("after_abort");

    // Runt terminating at w=5.
    send_frame(36, 0, 0, 0, 1'b0, 1'b0, 32'd10, 32'h0A000004, stamp, ts);
    model_frame(36, 0, 0, 0, 1'b0, stamp, ts, 32'h0A000004);
    idle_gap(1, 1'b0);
    check_all("runt");
    check("runt.err_abs", rx_err_count, 32'd2);

    // Latency saturation: stamp 0, ts FF000000.
    global_counter = 32'hFFFFFFFF;
    send_frame(64, 0, 0, 0, 1'b0, 1'b1, 32'hFF000000, 32'h0A000005, stamp, ts);
    model_frame(64, 0, 0, 0, 1'b0, stamp, ts, 32'h0A000005);
    idle_gap(1, 1'b0);
    check_all("latsat");
    check("latsat.lat_abs", {8'h00, rx_latency}, 32'h00FFFFFF);
    check("latsat.max_abs", {8'h00, rx_latency_max}, 32'h00FFFFFF);

    // Reset in the middle of a frame (after w=6).
    send_frame(100, 0, 0, 7, 1'b0, 1'b0, 32'd5, 32'h0A000006, stamp, ts);
    @(negedge sys_clk);
    sys_rst = 1'b1; xgmii_rxd = IDLE_W; xgmii_rxc = 8'hFF;
    model_reset();
    @(negedge sys_clk);
    check_all("midrst");
    sys_rst = 1'b0;
    send_frame(64, 0, 0, 0, 1'b0, 1'b0, 32'd333, 32'h0A000007, stamp, ts);
    model_frame(64, 0, 0, 0, 1'b0, stamp, ts, 32'h0A000007);
    idle_gap(1, 1'b0);
    check_all("post_rst");

    // Oversize frame.
    send_frame(16400, 0, 0, 0, 1'b0, 1'b0, 32'd1, 32'h0A000008, stamp, ts);
    model_frame(16400, 0, 0, 0, 1'b0, stamp, ts, 32'h0A000008);
    idle_gap(1, 1'b0);
    check_all("oversize");

    // Randomized traffic mix.
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      if (it == 79 && kind == 8) kind = 0;
      len = $urandom_range(56, 200);
      ip = $urandom;
      tsarg = $urandom_range(0, 5000);
      tsabs = 1'b0; bad = 0; ab = 0; tr = 0;
      case (kind)
        5: bad = $urandom_range(1, 4);
        6: len = $urandom_range(8, 55);
        7: ab = $urandom_range(1, len / 8);
        8: tr = $urandom_range(1, len / 8 + 1);
        9: tsarg = $urandom_range(32'h0100_0000, 32'hF000_0000);
        default: ;
      endcase
      osh = (kind != 8) && ($urandom_range(0, 5) == 0);
      gap = (kind == 8) ? 0 : $urandom_range(0, 2);
      send_frame(len, bad, ab, tr, osh, tsabs, tsarg, ip, stamp, ts);
      model_frame(len, bad, ab, tr, osh, stamp, ts, ip);
      if (gap > 0) begin
        idle_gap(gap, ($urandom_range(0, 3) == 0));
        check_all($sformatf("rnd%0d", it));
      end
    end

    idle_gap(2, 1'b1);
    check_all("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
